// File: rtl/alarm_trigger_pkg.sv
// -----------------------------------------------------------------------------
// alarm_trigger_pkg
// Shared definitions for the alarm front end:
//   - alarm_state_t : FSM state encoding (DISARMED / ARMED / FIRING / SNOOZE)
//   - BCD field limits used by the wrap-around incrementers
//   - snz_used_width: width of the per-event snooze counter (at least 2 bits)
// -----------------------------------------------------------------------------
package alarm_trigger_pkg;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        FIRING   = 2'd2,
        SNOOZE   = 2'd3
    } alarm_state_t;

    localparam logic [7:0] BCD_HOUR_MAX = 8'h23;
    localparam logic [7:0] BCD_MIN_MAX  = 8'h59;
    localparam logic [7:0] BCD_ZERO     = 8'h00;

    // Smallest width (never below 2) that can hold 0..max_snoozes.
    function automatic int snz_used_width(input int max_snoozes);
        int w;
        w = 2;
        while ((1 << w) <= max_snoozes) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/alarm_trigger_if.sv
// -----------------------------------------------------------------------------
// alarm_trigger_if
// Bundles the time inputs, user controls and alarm outputs of alarm_trigger.
//   master : the side that supplies time/buttons and observes the alarm outputs
//   slave  : the alarm_trigger block itself
// Signals:
//   sec_tick              1-cycle pulse once per second
//   cur_hour/min/sec      running time, BCD
//   alarm_en, set_mode    levels
//   btn_hour, btn_min     1-cycle edit pulses (active only in set_mode)
//   snooze, dismiss       1-cycle pulses
//   alm_hour, alm_min     alarm time registers, BCD
//   cc1                   alarm sounding level
//   cc2                   1-cycle strike pulse
//   snoozing              high while snoozed
// -----------------------------------------------------------------------------
interface alarm_trigger_if;

    logic       sec_tick;
    logic [7:0] cur_hour;
    logic [7:0] cur_min;
    logic [7:0] cur_sec;
    logic       alarm_en;
    logic       set_mode;
    logic       btn_hour;
    logic       btn_min;
    logic       snooze;
    logic       dismiss;
    logic [7:0] alm_hour;
    logic [7:0] alm_min;
    logic       cc1;
    logic       cc2;
    logic       snoozing;

    modport master (
        output sec_tick, cur_hour, cur_min, cur_sec,
        output alarm_en, set_mode, btn_hour, btn_min, snooze, dismiss,
        input  alm_hour, alm_min, cc1, cc2, snoozing
    );

    modport slave (
        input  sec_tick, cur_hour, cur_min, cur_sec,
        input  alarm_en, set_mode, btn_hour, btn_min, snooze, dismiss,
        output alm_hour, alm_min, cc1, cc2, snoozing
    );

endinterface

// File: rtl/alarm_trigger_bcd_wrap_inc.sv
// -----------------------------------------------------------------------------
// bcd_wrap_inc
// Combinational two-digit BCD incrementer with wrap to 00 after MAX.
// Shared by the alarm hour/minute editors and usable by timekeeping counters.
// Ports:
//   value      in  8  current BCD value (00..MAX)
//   next_value out 8  value + 1 in BCD, or 00 when value has reached MAX
// -----------------------------------------------------------------------------
module bcd_wrap_inc #(
    parameter logic [7:0] MAX = 8'h59
) (
    input  logic [7:0] value,
    output logic [7:0] next_value
);

    always_comb begin
        // For valid BCD, binary ordering equals decimal ordering, so >= also
        // folds any out-of-range value back to 00.
        if (value >= MAX) begin
            next_value = 8'h00;
        end else if (value[3:0] >= 4'd9) begin
            next_value = {value[7:4] + 4'd1, 4'h0};
        end else begin
            next_value = {value[7:4], value[3:0] + 4'd1};
        end
    end

endmodule

// File: rtl/alarm_trigger.sv
// -----------------------------------------------------------------------------
// alarm_trigger
// Alarm front end of the digital clock. Holds the alarm time (BCD hh:mm),
// compares it with the running time on each second tick and drives the
// cc1 (sounding level) / cc2 (strike pulse) pair consumed by the chime block.
// Supports bounded snooze, dismiss, auto-timeout and an edit (set) mode.
// Ports:
//   cclk  in  system clock, all state on posedge
//   rst   in  asynchronous active-high reset
//   bus   alarm_trigger_if.slave (time, controls, alarm outputs)
// Parameters:
//   RING_SECS  sec_ticks spent FIRING before auto-timeout (1..255)
//   SNOOZE_MIN snooze length in minutes (1..999)
//   SNOOZE_MAX snoozes allowed per alarm event (0 disables snooze)
//   RST_HOUR / RST_MIN alarm time loaded at reset (BCD)
// -----------------------------------------------------------------------------
module alarm_trigger
    import alarm_trigger_pkg::*;
#(
    parameter int         RING_SECS  = 60,
    parameter int         SNOOZE_MIN = 5,
    parameter int         SNOOZE_MAX = 3,
    parameter logic [7:0] RST_HOUR   = 8'h07,
    parameter logic [7:0] RST_MIN    = 8'h00
) (
    input  logic            cclk,
    input  logic            rst,
    alarm_trigger_if.slave  bus
);

    localparam int               SNZ_W     = snz_used_width(SNOOZE_MAX);
    localparam logic [7:0]       RING_LAST = 8'(RING_SECS - 1);
    localparam logic [15:0]      SNZ_LOAD  = 16'(SNOOZE_MIN * 60);
    localparam logic [SNZ_W-1:0] SNZ_LIMIT = SNZ_W'(SNOOZE_MAX);

    alarm_state_t     state;
    alarm_state_t     state_nxt;
    logic [7:0]       ring_cnt;
    logic [7:0]       ring_nxt;
    logic [15:0]      snz_cnt;
    logic [15:0]      snz_cnt_nxt;
    logic [SNZ_W-1:0] snz_used;
    logic [SNZ_W-1:0] snz_used_nxt;
    logic             cc2_nxt;

    logic [7:0]       alm_hour;
    logic [7:0]       alm_min;
    logic [7:0]       hour_inc;
    logic [7:0]       min_inc;
    logic             cc1;
    logic             cc2;
    logic             snoozing;

    logic             match;
    logic             snooze_ok;

    bcd_wrap_inc #(.MAX(BCD_HOUR_MAX)) u_hour_inc (
        .value      (alm_hour),
        .next_value (hour_inc)
    );

    bcd_wrap_inc #(.MAX(BCD_MIN_MAX)) u_min_inc (
        .value      (alm_min),
        .next_value (min_inc)
    );

    // Compared against the alarm registers before any same-cycle edit.
    assign match = bus.sec_tick
                 && (bus.cur_hour == alm_hour)
                 && (bus.cur_min  == alm_min)
                 && (bus.cur_sec  == BCD_ZERO)
                 && !bus.set_mode;

    assign snooze_ok = bus.snooze && (snz_used < SNZ_LIMIT);

    always_comb begin
        state_nxt    = state;
        ring_nxt     = ring_cnt;
        snz_cnt_nxt  = snz_cnt;
        snz_used_nxt = snz_used;
        cc2_nxt      = 1'b0;

        if (!bus.alarm_en) begin
            state_nxt    = DISARMED;
            snz_used_nxt = '0;
        end else begin
            case (state)
                DISARMED: begin
                    state_nxt = ARMED;
                end
                ARMED: begin
                    if (match) begin
                        state_nxt    = FIRING;
                        ring_nxt     = '0;
                        snz_used_nxt = '0;
                        cc2_nxt      = 1'b1;
                    end
                end
                FIRING: begin
                    // dismiss > snooze > timeout > ordinary strike tick
                    if (bus.dismiss) begin
                        state_nxt    = ARMED;
                        snz_used_nxt = '0;
                    end else if (snooze_ok) begin
                        state_nxt    = SNOOZE;
                        snz_cnt_nxt  = SNZ_LOAD;
                        snz_used_nxt = snz_used + SNZ_W'(1);
                    end else if (bus.sec_tick) begin
                        if (ring_cnt == RING_LAST) begin
                            state_nxt    = ARMED;
                            snz_used_nxt = '0;
                        end else begin
                            ring_nxt = ring_cnt + 8'd1;
                            cc2_nxt  = 1'b1;
                        end
                    end
                end
                SNOOZE: begin
                    if (bus.dismiss) begin
                        state_nxt    = ARMED;
                        snz_used_nxt = '0;
                    end else if (bus.sec_tick) begin
                        if (snz_cnt == 16'd1) begin
                            state_nxt = FIRING;
                            ring_nxt  = '0;
                            cc2_nxt   = 1'b1;
                        end else begin
                            snz_cnt_nxt = snz_cnt - 16'd1;
                        end
                    end
                end
                default: begin
                    state_nxt = DISARMED;
                end
            endcase
        end
    end

    always_ff @(posedge cclk or posedge rst) begin
        if (rst) begin
            state    <= DISARMED;
            ring_cnt <= '0;
            snz_cnt  <= '0;
            snz_used <= '0;
            cc1      <= 1'b0;
            cc2      <= 1'b0;
            snoozing <= 1'b0;
        end else begin
            state    <= state_nxt;
            ring_cnt <= ring_nxt;
            snz_cnt  <= snz_cnt_nxt;
            snz_used <= snz_used_nxt;
            // Outputs decoded from the next state so they are registered
            // yet aligned with the state they describe.
            cc1      <= (state_nxt == FIRING);
            cc2      <= cc2_nxt;
            snoozing <= (state_nxt == SNOOZE);
        end
    end

    // Alarm time editing; hour and minute update independently.
    always_ff @(posedge cclk or posedge rst) begin
        if (rst) begin
            alm_hour <= RST_HOUR;
            alm_min  <= RST_MIN;
        end else if (bus.set_mode) begin
            if (bus.btn_hour) begin
                alm_hour <= hour_inc;
            end
            if (bus.btn_min) begin
                alm_min <= min_inc;
            end
        end
    end

    assign bus.alm_hour = alm_hour;
    assign bus.alm_min  = alm_min;
    assign bus.cc1      = cc1;
    assign bus.cc2      = cc2;
    assign bus.snoozing = snoozing;

endmodule

// File: tb/tb_alarm_trigger.sv
// -----------------------------------------------------------------------------
// tb_alarm_trigger
// Directed scenarios followed by a randomized run; every cycle the DUT outputs
// are compared with a behavioural model that tracks the alarm as decimal
// hour/minute values and "ticks remaining" countdowns.
// -----------------------------------------------------------------------------
module tb_alarm_trigger;

    localparam int RING_SECS  = 3;
    localparam int SNOOZE_MIN = 1;
    localparam int SNOOZE_MAX = 3;

    localparam int M_OFF     = 0;
    localparam int M_ARMED   = 1;
    localparam int M_RINGING = 2;
    localparam int M_SNOOZED = 3;

    logic cclk = 1'b0;
    logic rst;

    always #5 cclk = ~cclk;

    alarm_trigger_if bus ();

    alarm_trigger #(
        .RING_SECS  (RING_SECS),
        .SNOOZE_MIN (SNOOZE_MIN),
        .SNOOZE_MAX (SNOOZE_MAX),
        .RST_HOUR   (8'h07),
        .RST_MIN    (8'h00)
    ) dut (
        .cclk (cclk),
        .rst  (rst),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    int m_mode;
    int m_hr;
    int m_mn;
    int m_ring_left;
    int m_snz_left;
    int m_snz_taken;
    bit m_cc2;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) + (v % 10));
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode      = M_OFF;
        m_hr        = 7;
        m_mn        = 0;
        m_ring_left = 0;
        m_snz_left  = 0;
        m_snz_taken = 0;
        m_cc2       = 1'b0;
    endtask

    // Applies the inputs that the DUT sampled on the edge just passed.
    task automatic model_update();
        bit match;
        match = bus.sec_tick && (bus.cur_hour == to_bcd(m_hr)) && (bus.cur_min == to_bcd(m_mn))
                && (bus.cur_sec == 8'h00) && !bus.set_mode;
        m_cc2 = 1'b0;
        if (bus.set_mode) begin
            if (bus.btn_hour) m_hr = (m_hr + 1) % 24;
            if (bus.btn_min)  m_mn = (m_mn + 1) % 60;
        end
        if (!bus.alarm_en) begin
            m_mode      = M_OFF;
            m_snz_taken = 0;
        end else if (m_mode == M_OFF) begin
            m_mode = M_ARMED;
        end else if (m_mode == M_ARMED) begin
            if (match) begin
                m_mode      = M_RINGING;
                m_ring_left = RING_SECS;
                m_snz_taken = 0;
                m_cc2       = 1'b1;
            end
        end else if (m_mode == M_RINGING) begin
            if (bus.dismiss) begin
                m_mode      = M_ARMED;
                m_snz_taken = 0;
            end else if (bus.snooze && m_snz_taken < SNOOZE_MAX) begin
                m_mode      = M_SNOOZED;
                m_snz_left  = SNOOZE_MIN * 60;
                m_snz_taken = m_snz_taken + 1;
            end else if (bus.sec_tick) begin
                m_ring_left = m_ring_left - 1;
                if (m_ring_left == 0) begin
                    m_mode      = M_ARMED;
                    m_snz_taken = 0;
                end else begin
                    m_cc2 = 1'b1;
                end
            end
        end else begin
            if (bus.dismiss) begin
                m_mode      = M_ARMED;
                m_snz_taken = 0;
            end else if (bus.sec_tick) begin
                m_snz_left = m_snz_left - 1;
                if (m_snz_left == 0) begin
                    m_mode      = M_RINGING;
                    m_ring_left = RING_SECS;
                    m_cc2       = 1'b1;
                end
            end
        end
    endtask

    task automatic check_outputs(input string where);
        chk({where, ".cc1"},      8'(bus.cc1),      8'(m_mode == M_RINGING));
        chk({where, ".cc2"},      8'(bus.cc2),      8'(m_cc2));
        chk({where, ".snoozing"}, 8'(bus.snoozing), 8'(m_mode == M_SNOOZED));
        chk({where, ".alm_hour"}, bus.alm_hour,     to_bcd(m_hr));
        chk({where, ".alm_min"},  bus.alm_min,      to_bcd(m_mn));
    endtask

    task automatic step(input string where);
        @(posedge cclk);
        model_update();
        #1;
        check_outputs(where);
    endtask

    task automatic tick(input string where);
        bus.sec_tick = 1'b1;
        step(where);
        bus.sec_tick = 1'b0;
    endtask

    task automatic tick_n(input int n, input string where);
        for (int i = 0; i < n; i++) begin
            tick(where);
            step(where);
        end
    endtask

    task automatic pulse_snooze(input string where);
        bus.snooze = 1'b1;
        step(where);
        bus.snooze = 1'b0;
    endtask

    task automatic pulse_dismiss(input string where);
        bus.dismiss = 1'b1;
        step(where);
        bus.dismiss = 1'b0;
    endtask

    task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        bus.cur_hour = h;
        bus.cur_min  = m;
        bus.cur_sec  = s;
    endtask

    initial begin
        rst          = 1'b1;
        bus.sec_tick = 1'b0;
        bus.alarm_en = 1'b0;
        bus.set_mode = 1'b0;
        bus.btn_hour = 1'b0;
        bus.btn_min  = 1'b0;
        bus.snooze   = 1'b0;
        bus.dismiss  = 1'b0;
        set_time(8'h00, 8'h00, 8'h00);
        model_reset();

        // Reset state
        repeat (2) @(posedge cclk);
        #1;
        chk("rst.cc1",      8'(bus.cc1),      8'h00);
        chk("rst.cc2",      8'(bus.cc2),      8'h00);
        chk("rst.snoozing", 8'(bus.snoozing), 8'h00);
        chk("rst.alm_hour", bus.alm_hour,     8'h07);
        chk("rst.alm_min",  bus.alm_min,      8'h00);
        @(negedge cclk);
        rst = 1'b0;
        step("idle_disarmed");
        bus.alarm_en = 1'b1;
        step("arm");

        // Alarm fires at 07:00:00, strikes on following ticks
        set_time(8'h06, 8'h59, 8'h59);
        tick("t1_pre");
        chk("t1_no_early", 8'(bus.cc1), 8'h00);
        set_time(8'h07, 8'h00, 8'h00);
        tick("t1_fire");
        chk("t1_fire_cc1", 8'(bus.cc1), 8'h01);
        chk("t1_fire_cc2", 8'(bus.cc2), 8'h01);
        step("t1_hold");
        chk("t1_hold_cc2", 8'(bus.cc2), 8'h00);
        set_time(8'h07, 8'h00, 8'h01);
        tick("t1_strike");
        chk("t1_strike_cc2", 8'(bus.cc2), 8'h01);

        // Timeout after RING_SECS ticks, no re-fire later in the minute
        step("t2_gap");
        set_time(8'h07, 8'h00, 8'h02);
        tick("t2_tick2");
        chk("t2_still_firing", 8'(bus.cc1), 8'h01);
        step("t2_gap");
        set_time(8'h07, 8'h00, 8'h03);
        tick("t2_timeout");
        chk("t2_timeout_cc1", 8'(bus.cc1), 8'h00);
        chk("t2_timeout_cc2", 8'(bus.cc2), 8'h00);
        set_time(8'h07, 8'h00, 8'h05);
        tick("t2_no_refire");
        chk("t2_no_refire_cc1", 8'(bus.cc1), 8'h00);

        // Snooze up to SNOOZE_MAX times, then snooze is ignored
        set_time(8'h07, 8'h00, 8'h00);
        tick("t3_fire");
        for (int k = 1; k <= SNOOZE_MAX; k++) begin
            pulse_snooze("t3_snooze");
            chk($sformatf("t3_snz%0d_snoozing", k), 8'(bus.snoozing), 8'h01);
            chk($sformatf("t3_snz%0d_cc1", k),      8'(bus.cc1),      8'h00);
            set_time(8'h07, 8'h01, 8'h30);
            tick_n(SNOOZE_MIN * 60 - 1, "t3_wait");
            chk($sformatf("t3_snz%0d_still", k), 8'(bus.snoozing), 8'h01);
            tick("t3_refire");
            chk($sformatf("t3_snz%0d_refire_cc1", k), 8'(bus.cc1), 8'h01);
            chk($sformatf("t3_snz%0d_refire_cc2", k), 8'(bus.cc2), 8'h01);
            step("t3_gap");
        end
        pulse_snooze("t3_snooze_over");
        chk("t3_ignored_cc1",      8'(bus.cc1),      8'h01);
        chk("t3_ignored_snoozing", 8'(bus.snoozing), 8'h00);
        pulse_dismiss("t3_dismiss");
        chk("t3_dismiss_cc1", 8'(bus.cc1), 8'h00);

        // Set mode editing and match suppression
        bus.set_mode = 1'b1;
        for (int i = 0; i < 23; i++) begin
            bus.btn_hour = 1'b1;
            step("t4_hour");
            bus.btn_hour = 1'b0;
        end
        chk("t4_hour_wrap", bus.alm_hour, 8'h06);
        for (int i = 0; i < 59; i++) begin
            bus.btn_min = 1'b1;
            step("t4_min");
            bus.btn_min = 1'b0;
        end
        chk("t4_min_59", bus.alm_min, 8'h59);
        bus.btn_min = 1'b1;
        step("t4_min_wrap");
        bus.btn_min = 1'b0;
        chk("t4_min_wrap", bus.alm_min,  8'h00);
        chk("t4_no_carry", bus.alm_hour, 8'h06);
        set_time(8'h06, 8'h00, 8'h00);
        tick("t4_match_in_set");
        chk("t4_no_fire", 8'(bus.cc1), 8'h00);
        bus.btn_hour = 1'b1;
        bus.btn_min  = 1'b1;
        step("t4_both");
        bus.btn_hour = 1'b0;
        bus.btn_min  = 1'b0;
        chk("t4_both_hour", bus.alm_hour, 8'h07);
        chk("t4_both_min",  bus.alm_min,  8'h01);
        bus.set_mode = 1'b0;

        // Same-cycle snooze+dismiss; disarm mid-snooze clears snooze count
        set_time(8'h07, 8'h01, 8'h00);
        tick("t5_fire");
        chk("t5_fire_cc1", 8'(bus.cc1), 8'h01);
        bus.snooze  = 1'b1;
        bus.dismiss = 1'b1;
        step("t5_both");
        bus.snooze  = 1'b0;
        bus.dismiss = 1'b0;
        chk("t5_both_cc1",      8'(bus.cc1),      8'h00);
        chk("t5_both_snoozing", 8'(bus.snoozing), 8'h00);
        tick("t5_refire");
        pulse_snooze("t5_snooze");
        chk("t5_snoozing", 8'(bus.snoozing), 8'h01);
        bus.alarm_en = 1'b0;
        step("t5_disarm");
        chk("t5_disarm_snoozing", 8'(bus.snoozing), 8'h00);
        bus.alarm_en = 1'b1;
        step("t5_rearm");
        tick("t5_fire2");
        for (int k = 1; k <= SNOOZE_MAX; k++) begin
            pulse_snooze("t5_snooze");
            chk($sformatf("t5_snz%0d_snoozing", k), 8'(bus.snoozing), 8'h01);
            if (k < SNOOZE_MAX) begin
                set_time(8'h07, 8'h02, 8'h10);
                tick_n(SNOOZE_MIN * 60, "t5_wait");
                set_time(8'h07, 8'h01, 8'h00);
            end
        end
        pulse_dismiss("t5_dismiss_snooze");
        chk("t5_dismiss_snoozing", 8'(bus.snoozing), 8'h00);

        // Randomized run against the model
        for (int c = 0; c < 3000; c++) begin
            bus.sec_tick = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) begin
                set_time(to_bcd(m_hr), to_bcd(m_mn),
                         ($urandom_range(0, 2) == 0) ? 8'h00 : to_bcd($urandom_range(1, 59)));
            end else begin
                set_time(to_bcd($urandom_range(0, 23)), to_bcd($urandom_range(0, 59)),
                         to_bcd($urandom_range(0, 59)));
            end
            bus.snooze   = !bus.sec_tick && ($urandom_range(0, 40) == 0);
            bus.dismiss  = ($urandom_range(0, 199) == 0);
            bus.alarm_en = ($urandom_range(0, 299) != 0);
            bus.set_mode = ($urandom_range(0, 9) == 0);
            bus.btn_hour = ($urandom_range(0, 7) == 0);
            bus.btn_min  = ($urandom_range(0, 7) == 0);
            step("rand");
        end
        bus.sec_tick = 1'b0;
        bus.snooze   = 1'b0;
        bus.dismiss  = 1'b0;
        bus.set_mode = 1'b0;
        bus.btn_hour = 1'b0;
        bus.btn_min  = 1'b0;
        bus.alarm_en = 1'b0;
        step("t6_disarm");
        bus.alarm_en = 1'b1;
        step("t6_arm");
        if (m_hr == 7 && m_mn == 0) begin
            bus.set_mode = 1'b1;
            bus.btn_min  = 1'b1;
            step("t6_edit");
            bus.set_mode = 1'b0;
            bus.btn_min  = 1'b0;
        end

        // Asynchronous reset between edges while firing
        set_time(to_bcd(m_hr), to_bcd(m_mn), 8'h00);
        bus.sec_tick = 1'b1;
        @(posedge cclk);
        model_update();
        #1;
        check_outputs("t6_fire");
        bus.sec_tick = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_cc1",      8'(bus.cc1),      8'h00);
        chk("t6_rst_cc2",      8'(bus.cc2),      8'h00);
        chk("t6_rst_snoozing", 8'(bus.snoozing), 8'h00);
        chk("t6_rst_alm_hour", bus.alm_hour,     8'h07);
        chk("t6_rst_alm_min",  bus.alm_min,      8'h00);
        model_reset();
        @(negedge cclk);
        rst = 1'b0;
        step("t6_after_rst");
        set_time(8'h07, 8'h00, 8'h00);
        tick("t6_fire_again");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
